// File: rtl/sm3_msg_loader.sv
// SM3 message loader: packs a 32-bit word stream big-endian into the five 512-bit core
// buses, launches the core, and returns the 256-bit hash on a valid/ready output.
module sm3_msg_loader #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic [1:0]   s_nbytes,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [511:0] core_datain1,
  output logic [511:0] core_datain2,
  output logic [511:0] core_datain3,
  output logic [511:0] core_datain4,
  output logic [511:0] core_datain5,
  output logic [31:0]  core_l,
  output logic         core_start,
  input  logic [255:0] core_hashout,
  input  logic         core_valid,
  output logic [255:0] m_hash,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         err,
  output logic         busy
);

  localparam int         MAX_GROUPS = 5;
  localparam int         DEPTH      = 16 * MAX_GROUPS;
  localparam logic [6:0] DEPTH_W    = 7'(DEPTH);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [6:0]     wcnt_q, wcnt_d;
  logic           drop_q, drop_d;
  logic [31:0]    core_l_q, core_l_d;
  logic [9:0]     tmo_q, tmo_d;
  logic [255:0]   m_hash_q, m_hash_d;
  logic           m_valid_q, m_valid_d;
  logic           err_q, err_d;
  logic           s_ready_q, busy_q, core_start_q;
  logic [31:0]    mem_q [DEPTH];
  logic           buf_we, buf_clr;
  logic [31:0]    keep_mask, wdata;
  logic [2:0]     nb1;
  logic [2559:0]  flat;

  // Only the leading s_nbytes+1 bytes of a final word are part of the message.
  always_comb begin
    keep_mask = 32'hFFFF_FFFF;
    if (s_last) begin
      case (s_nbytes)
        2'd0:    keep_mask = 32'hFF00_0000;
        2'd1:    keep_mask = 32'hFFFF_0000;
        2'd2:    keep_mask = 32'hFFFF_FF00;
        default: keep_mask = 32'hFFFF_FFFF;
      endcase
    end else begin
      keep_mask = 32'hFFFF_FFFF;
    end
  end

  assign wdata = s_data & keep_mask;
  assign nb1   = {1'b0, s_nbytes} + 3'd1;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    drop_d    = drop_q;
    core_l_d  = core_l_q;
    tmo_d     = tmo_q;
    m_hash_d  = m_hash_q;
    m_valid_d = m_valid_q;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    buf_clr   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_valid && s_ready_q) begin
          if (drop_q || (wcnt_q == DEPTH_W)) begin
            // Oversized message: swallow the rest, then report once at its end.
            if (s_last) begin
              err_d   = 1'b1;
              buf_clr = 1'b1;
              wcnt_d  = 7'd0;
              drop_d  = 1'b0;
            end else begin
              drop_d  = 1'b1;
            end
          end else begin
            buf_we = 1'b1;
            wcnt_d = wcnt_q + 7'd1;
            if (s_last) begin
              core_l_d = {20'd0, wcnt_q, 5'd0} + {26'd0, nb1, 3'd0};
              state_d  = LAUNCH;
            end else begin
              state_d  = COLLECT;
            end
          end
        end else begin
          state_d = COLLECT;
        end
      end
      LAUNCH: begin
        // The launch cycle counts as the first cycle of the timeout window.
        tmo_d   = 10'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          m_hash_d  = core_hashout;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          buf_clr  = 1'b1;
          wcnt_d   = 7'd0;
          core_l_d = 32'd0;
          state_d  = COLLECT;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          buf_clr   = 1'b1;
          wcnt_d    = 7'd0;
          core_l_d  = 32'd0;
          state_d   = COLLECT;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      wcnt_q       <= 7'd0;
      drop_q       <= 1'b0;
      core_l_q     <= 32'd0;
      tmo_q        <= 10'd0;
      m_hash_q     <= 256'd0;
      m_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      drop_q       <= drop_d;
      core_l_q     <= core_l_d;
      tmo_q        <= tmo_d;
      m_hash_q     <= m_hash_d;
      m_valid_q    <= m_valid_d;
      err_q        <= err_d;
      s_ready_q    <= (state_d == COLLECT);
      busy_q       <= (state_d != COLLECT);
      core_start_q <= (state_d == LAUNCH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (buf_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (buf_we) begin
      mem_q[wcnt_q] <= wdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat[2559 - 32*g -: 32] = mem_q[g];
  end

  assign core_datain1 = flat[2559:2048];
  assign core_datain2 = flat[2047:1536];
  assign core_datain3 = flat[1535:1024];
  assign core_datain4 = flat[1023:512];
  assign core_datain5 = flat[511:0];
  assign core_l       = core_l_q;
  assign core_start   = core_start_q;
  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign m_hash       = m_hash_q;
  assign m_valid      = m_valid_q;

endmodule
